// File: rtl/input_module.sv
// input_module: NoC ingress packet injector. Buffers host words in a FIFO and
// frames them into one AXI-Stream packet per START command.
`default_nettype none

module input_module #(
  parameter int TDATAW = 32,
  parameter int TDESTW = 4,
  parameter int TIDW   = 2,
  parameter int DEPTH  = 8,
  parameter int LENW   = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WR_EN,
  input  logic [TDATAW-1:0]        WR_DATA,
  output logic                     WR_FULL,
  output logic [$clog2(DEPTH):0]   FIFO_CNT,
  input  logic                     START,
  input  logic [TDESTW-1:0]        IDEST_I,
  input  logic [TIDW-1:0]          IID_I,
  input  logic [LENW-1:0]          ILEN_I,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     AXIS_M_TVALID,
  input  logic                     AXIS_M_TREADY,
  output logic [TDATAW-1:0]        AXIS_M_TDATA,
  output logic                     AXIS_M_TLAST,
  output logic [TIDW-1:0]          AXIS_M_TID,
  output logic [TDESTW-1:0]        AXIS_M_TDEST
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LENW-1:0]     len_q, len_d;
  logic [LENW-1:0]     beat_q, beat_d;
  logic [TDESTW-1:0]   dest_q, dest_d;
  logic [TIDW-1:0]     id_q, id_d;
  logic                done_q, done_d;
  logic [AW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [TDATAW-1:0]   mem [DEPTH];

  logic tvalid, pop, push, full, last;

  always_comb begin
    tvalid = (state_q == S_SEND) && (cnt_q != '0);
    pop    = tvalid && AXIS_M_TREADY;
    last   = (state_q == S_SEND) && (beat_q == len_q);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    full   = (cnt_q == CW'(DEPTH)) && !pop;
    push   = WR_EN && !full;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    dest_d  = dest_q;
    id_d    = id_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SEND;
          len_d   = ILEN_I;
          dest_d  = IDEST_I;
          id_d    = IID_I;
          beat_d  = '0;
        end
      end
      S_SEND: begin
        if (pop) begin
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + LENW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      dest_q  <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      dest_q  <= dest_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= WR_DATA;
  end

  // Storage is not reset; masking keeps TDATA at zero whenever nothing is held.
  assign AXIS_M_TDATA  = (cnt_q != '0) ? mem[rd_ptr_q] : '0;
  assign AXIS_M_TVALID = tvalid;
  assign AXIS_M_TLAST  = last;
  assign AXIS_M_TID    = id_q;
  assign AXIS_M_TDEST  = dest_q;
  assign WR_FULL       = full;
  assign FIFO_CNT      = cnt_q;
  assign BUSY          = (state_q == S_SEND);
  assign DONE          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_input_module.sv
// tb_input_module: drives input_module and compares every cycle against a
// queue-based model of the packet injector.
`default_nettype none

module tb_input_module;
  localparam int TDATAW = 32;
  localparam int TDESTW = 4;
  localparam int TIDW   = 2;
  localparam int DEPTH  = 8;
  localparam int LENW   = 8;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              WR_EN;
  logic [TDATAW-1:0] WR_DATA;
  logic              WR_FULL;
  logic [3:0]        FIFO_CNT;
  logic              START;
  logic [TDESTW-1:0] IDEST_I;
  logic [TIDW-1:0]   IID_I;
  logic [LENW-1:0]   ILEN_I;
  logic              BUSY, DONE;
  logic              TVALID, TREADY, TLAST;
  logic [TDATAW-1:0] TDATA;
  logic [TIDW-1:0]   TID;
  logic [TDESTW-1:0] TDEST;

  always #5 CLK = ~CLK;

  input_module #(.TDATAW(TDATAW), .TDESTW(TDESTW), .TIDW(TIDW), .DEPTH(DEPTH), .LENW(LENW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL), .FIFO_CNT(FIFO_CNT),
    .START(START), .IDEST_I(IDEST_I), .IID_I(IID_I), .ILEN_I(ILEN_I),
    .BUSY(BUSY), .DONE(DONE),
    .AXIS_M_TVALID(TVALID), .AXIS_M_TREADY(TREADY), .AXIS_M_TDATA(TDATA),
    .AXIS_M_TLAST(TLAST), .AXIS_M_TID(TID), .AXIS_M_TDEST(TDEST)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [TDATAW-1:0] mq[$];
  bit                m_busy = 0;
  bit                m_done = 0;
  int                m_len  = 0;
  int                m_beat = 0;
  logic [TDESTW-1:0] m_dest = '0;
  logic [TIDW-1:0]   m_id   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_done = 0; m_len = 0; m_beat = 0; m_dest = '0; m_id = '0;
  endtask

  // Check the current cycle at the falling edge, advance the model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic step();
    bit ev, pop, full;
    @(negedge CLK);
    ev   = m_busy && (mq.size() != 0);
    pop  = ev && TREADY;
    full = (mq.size() == DEPTH) && !pop;
    chk("fifo_cnt", 32'(FIFO_CNT), 32'(mq.size()));
    chk("tvalid", 32'(TVALID), 32'(ev));
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("done", 32'(DONE), 32'(m_done));
    chk("wr_full", 32'(WR_FULL), 32'(full));
    chk("tlast", 32'(TLAST), 32'(m_busy && (m_beat == m_len)));
    chk("tdest", 32'(TDEST), 32'(m_dest));
    chk("tid", 32'(TID), 32'(m_id));
    if (ev) chk("tdata", TDATA, mq[0]);
    if (RST_N) begin
      m_done = 0;
      if (m_busy) begin
        if (pop) begin
          if (m_beat == m_len) begin
            m_busy = 0;
            m_done = 1;
          end else begin
            m_beat++;
          end
        end
      end else if (START) begin
        m_busy = 1;
        m_len  = int'(ILEN_I);
        m_dest = IDEST_I;
        m_id   = IID_I;
        m_beat = 0;
      end
      if (pop) void'(mq.pop_front());
      if (WR_EN && !full) mq.push_back(WR_DATA);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_word(input logic [TDATAW-1:0] d);
    WR_EN = 1'b1; WR_DATA = d;
    step();
    WR_EN = 1'b0;
  endtask

  task automatic start_pkt(input int len, input int dest, input int id);
    START = 1'b1; ILEN_I = LENW'(len); IDEST_I = TDESTW'(dest); IID_I = TIDW'(id);
    step();
    START = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; WR_EN = 1'b0; WR_DATA = '0; START = 1'b0;
    IDEST_I = '0; IID_I = '0; ILEN_I = '0; TREADY = 1'b0;
    idle(2);
    chk("rst_tdata", TDATA, 32'h0);
    RST_N = 1'b1;
    idle(1);

    // Basic 4-beat packet at full throughput
    TREADY = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    start_pkt(3, 5, 1);
    idle(6);

    // Same packet under backpressure 1,0,0,...
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    start_pkt(3, 5, 1);
    for (int i = 0; i < 14; i++) begin
      TREADY = (i % 3 == 0);
      step();
    end
    TREADY = 1'b1;
    idle(3);

    // Underflow: one word with START, the rest trickle in
    START = 1'b1; ILEN_I = 8'd2; IDEST_I = 4'd7; IID_I = 2'd2;
    WR_EN = 1'b1; WR_DATA = 32'h11;
    step();
    START = 1'b0; WR_EN = 1'b0;
    idle(2);
    push_word(32'h22);
    idle(1);
    push_word(32'h33);
    idle(4);

    // Fill past full, then send across the pointer wrap while pushing
    for (int i = 0; i < 9; i++) push_word(32'h100 + 32'(i));
    START = 1'b1; ILEN_I = 8'd7; IDEST_I = 4'd12; IID_I = 2'd3;
    WR_EN = 1'b1; WR_DATA = 32'h200;
    step();
    START = 1'b0;
    for (int i = 1; i < 11; i++) begin
      WR_DATA = 32'h200 + 32'(i);
      step();
    end
    WR_EN = 1'b0;
    idle(3);
    if (mq.size() != 0) start_pkt(mq.size() - 1, 1, 0);
    idle(12);

    // Back-to-back: START held high, new fields offered mid-packet
    for (int i = 0; i < 6; i++) push_word(32'h300 + 32'(i));
    START = 1'b1; ILEN_I = 8'd2; IDEST_I = 4'd3; IID_I = 2'd2;
    step();
    IDEST_I = 4'd9; IID_I = 2'd1;
    idle(5);
    START = 1'b0;
    idle(4);

    // Asynchronous reset during beat 2 of 4
    for (int i = 0; i < 4; i++) push_word(32'hB0 + 32'(i));
    start_pkt(3, 6, 2);
    step();
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_tvalid", 32'(TVALID), 32'h0);
    chk("arst_busy", 32'(BUSY), 32'h0);
    chk("arst_cnt", 32'(FIFO_CNT), 32'h0);
    chk("arst_tlast", 32'(TLAST), 32'h0);
    model_reset();
    idle(2);
    RST_N = 1'b1;
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      WR_EN   = ($urandom % 2) == 0;
      WR_DATA = $urandom;
      START   = ($urandom % 8) == 0;
      ILEN_I  = (($urandom % 16) == 0) ? LENW'($urandom % 40) : LENW'($urandom % 6);
      IDEST_I = TDESTW'($urandom);
      IID_I   = TIDW'($urandom);
      TREADY  = ($urandom % 4) != 0;
      step();
    end
    WR_EN = 1'b0; START = 1'b0; TREADY = 1'b1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
